// File: rtl/mem_defs_pkg.sv
// Shared op codes, exception codes, enable constants and FSM state type for the
// multi-cycle MEM stage.
package mem_defs_pkg;

  localparam int MEM_OP_W = 4;

  localparam logic [MEM_OP_W-1:0] MEM_OP_NOP = 4'd0;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LW  = 4'd1;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LH  = 4'd2;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LHU = 4'd3;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LB  = 4'd4;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LBU = 4'd5;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SW  = 4'd6;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SH  = 4'd7;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SB  = 4'd8;

  localparam int EXP_NONE       = 0;
  localparam int EXP_MISS_ALIGN = 3;
  localparam int EXP_BUS_ERR    = 4;

  localparam logic RESET_ENABLE = 1'b1;
  localparam logic ENABLE       = 1'b1;
  localparam logic DISABLE      = 1'b0;
  localparam logic ENABLE_      = 1'b0;
  localparam logic DISABLE_     = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_stage_mc_align.sv
// Combinational lane logic: alignment check, byte enables, store replication
// and load sign/zero extension for one memory op.
module mem_align
  import mem_defs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [MEM_OP_W-1:0] op,
  input  logic [OFF_W-1:0]    off,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W-1:0]   rdata,
  output logic                is_mem,
  output logic                is_load,
  output logic                aligned,
  output logic                we,
  output logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   load_data
);

  localparam int NB = DATA_W / 8;

  // Only the low half-word of the shifted read data is ever consumed.
  logic [15:0] lane;
  assign lane = 16'(rdata >> {off, 3'b000});

  always_comb begin
    is_mem    = 1'b0;
    is_load   = 1'b0;
    aligned   = 1'b1;
    we        = 1'b0;
    be        = '0;
    wdata     = wr_data;
    load_data = rdata;
    case (op)
      MEM_OP_LW: begin
        is_mem  = 1'b1;
        is_load = 1'b1;
        aligned = (off == '0);
        be      = '1;
      end
      MEM_OP_LH, MEM_OP_LHU: begin
        is_mem    = 1'b1;
        is_load   = 1'b1;
        aligned   = ~off[0];
        be        = NB'(3) << off;
        load_data = (op == MEM_OP_LH) ? {{(DATA_W-16){lane[15]}}, lane[15:0]}
                                      : {{(DATA_W-16){1'b0}}, lane[15:0]};
      end
      MEM_OP_LB, MEM_OP_LBU: begin
        is_mem    = 1'b1;
        is_load   = 1'b1;
        be        = NB'(1) << off;
        load_data = (op == MEM_OP_LB) ? {{(DATA_W-8){lane[7]}}, lane[7:0]}
                                      : {{(DATA_W-8){1'b0}}, lane[7:0]};
      end
      MEM_OP_SW: begin
        is_mem  = 1'b1;
        we      = 1'b1;
        aligned = (off == '0);
        be      = '1;
      end
      MEM_OP_SH: begin
        is_mem  = 1'b1;
        we      = 1'b1;
        aligned = ~off[0];
        be      = NB'(3) << off;
        wdata   = {(DATA_W/16){wr_data[15:0]}};
      end
      MEM_OP_SB: begin
        is_mem = 1'b1;
        we     = 1'b1;
        be     = NB'(1) << off;
        wdata  = {NB{wr_data[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_mc.sv
// Multi-cycle MEM stage: req/ack data bus with variable latency, MEM/WB register.
// Optional ack timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage_mc
  import mem_defs_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int EXP_W      = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  busy,
  output logic [DATA_W-1:0]     fwd_data,
  input  logic [ADDR_W-1:0]     ex_pc,
  input  logic                  ex_en,
  input  logic [MEM_OP_W-1:0]   ex_mem_op,
  input  logic [DATA_W-1:0]     ex_mem_wr_data,
  input  logic [REG_ADDR_W-1:0] ex_dst_addr,
  input  logic                  ex_gpr_we_,
  input  logic [EXP_W-1:0]      ex_exp_code,
  input  logic [DATA_W-1:0]     ex_out,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W/8-1:0]   bus_be,
  input  logic                  bus_ack,
  input  logic                  bus_err,
  input  logic [DATA_W-1:0]     bus_rdata,
  output logic [ADDR_W-1:0]     mem_pc,
  output logic                  mem_en,
  output logic [REG_ADDR_W-1:0] mem_dst_addr,
  output logic                  mem_gpr_we_,
  output logic [EXP_W-1:0]      mem_exp_code,
  output logic [DATA_W-1:0]     mem_out
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  mem_state_t          state, state_nxt;
  logic                drop;
  logic [MEM_OP_W-1:0] op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                in_wait;
  logic [MEM_OP_W-1:0] op_a;
  logic [ADDR_W-1:0]   addr_a;
  logic [DATA_W-1:0]   wr_a;
  logic                is_mem, is_load, aligned, al_we;
  logic [NB-1:0]       al_be;
  logic [DATA_W-1:0]   al_wdata, load_data;
  logic                access, timed_out, err_hit, bubble;
  logic [EXP_W-1:0]    exp_c;
  logic [DATA_W-1:0]   out_c;
  logic                gpr_we_c;

  assign in_wait = (state == ST_WAIT);

  // While waiting, the bus and the load extension run off the captured copies.
  assign op_a   = in_wait ? op_q    : ex_mem_op;
  assign addr_a = in_wait ? addr_q  : ex_out[ADDR_W-1:0];
  assign wr_a   = in_wait ? wdata_q : ex_mem_wr_data;

  mem_align #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_align (
    .op        (op_a),
    .off       (addr_a[OFF_W-1:0]),
    .wr_data   (wr_a),
    .rdata     (bus_rdata),
    .is_mem    (is_mem),
    .is_load   (is_load),
    .aligned   (aligned),
    .we        (al_we),
    .be        (al_be),
    .wdata     (al_wdata),
    .load_data (load_data)
  );

  assign access = (reset != RESET_ENABLE) && !in_wait && ex_en && is_mem && aligned &&
                  (ex_exp_code == EXP_W'(EXP_NONE)) && !flush;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] to_cnt;

  assign timed_out = in_wait && (to_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset == RESET_ENABLE || !in_wait) to_cnt <= '0;
    else                                   to_cnt <= to_cnt + CNT_W'(1);
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign timed_out      = 1'b0;
`endif

  assign bus_req   = (reset != RESET_ENABLE) && (in_wait ? !timed_out : access);
  assign bus_we    = al_we;
  assign bus_be    = al_be;
  assign bus_wdata = al_wdata;
  assign bus_addr  = {addr_a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign busy      = bus_req && !bus_ack;
  assign err_hit   = (bus_req && bus_ack && bus_err) || timed_out;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (access && !bus_ack)     state_nxt = ST_WAIT;
      ST_WAIT: if (bus_ack || timed_out)   state_nxt = ST_IDLE;
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset == RESET_ENABLE) begin
      state   <= ST_IDLE;
      drop    <= DISABLE;
      op_q    <= MEM_OP_NOP;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (!in_wait && access) begin
        op_q    <= ex_mem_op;
        addr_q  <= ex_out[ADDR_W-1:0];
        wdata_q <= ex_mem_wr_data;
      end
      // A flushed transfer still runs to completion; its result becomes a bubble.
      if (in_wait && (bus_ack || timed_out)) drop <= DISABLE;
      else if (in_wait && flush)             drop <= ENABLE;
    end
  end

  assign bubble = flush || !ex_en || (in_wait && drop);

  always_comb begin
    exp_c = EXP_W'(EXP_NONE);
    if (ex_exp_code != EXP_W'(EXP_NONE)) exp_c = ex_exp_code;
    else if (is_mem && !aligned)         exp_c = EXP_W'(EXP_MISS_ALIGN);
    else if (err_hit)                    exp_c = EXP_W'(EXP_BUS_ERR);
  end

  assign out_c    = (is_load && exp_c == EXP_W'(EXP_NONE)) ? load_data : ex_out;
  assign gpr_we_c = (exp_c != EXP_W'(EXP_NONE)) ? DISABLE_ : ex_gpr_we_;
  assign fwd_data = out_c;

  always_ff @(posedge clk) begin
    if (reset == RESET_ENABLE) begin
      mem_pc       <= '0;
      mem_en       <= DISABLE;
      mem_dst_addr <= '0;
      mem_gpr_we_  <= DISABLE_;
      mem_exp_code <= '0;
      mem_out      <= '0;
    end else if (!stall && !busy) begin
      if (bubble) begin
        mem_pc       <= '0;
        mem_en       <= DISABLE;
        mem_dst_addr <= '0;
        mem_gpr_we_  <= DISABLE_;
        mem_exp_code <= '0;
        mem_out      <= '0;
      end else begin
        mem_pc       <= ex_pc;
        mem_en       <= ENABLE;
        mem_dst_addr <= ex_dst_addr;
        mem_gpr_we_  <= gpr_we_c;
        mem_exp_code <= exp_c;
        mem_out      <= out_c;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_mc.sv
// Directed bench for mem_stage_mc: zero-wait and multi-cycle loads/stores,
// misalignment, bus error, flush and reset during a transfer.
module tb_mem_stage_mc;

  logic        clk = 1'b0;
  logic        reset, stall, flush, busy;
  logic [31:0] fwd_data, ex_pc, ex_mem_wr_data, ex_out;
  logic        ex_en, ex_gpr_we_;
  logic [3:0]  ex_mem_op;
  logic [4:0]  ex_dst_addr;
  logic [2:0]  ex_exp_code;
  logic        bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic [31:0] mem_pc, mem_out;
  logic        mem_en, mem_gpr_we_;
  logic [4:0]  mem_dst_addr;
  logic [2:0]  mem_exp_code;

  int checks = 0;
  int failures = 0;
  int nb;

  always #5 clk = ~clk;

  mem_stage_mc dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
    .fwd_data(fwd_data), .ex_pc(ex_pc), .ex_en(ex_en), .ex_mem_op(ex_mem_op),
    .ex_mem_wr_data(ex_mem_wr_data), .ex_dst_addr(ex_dst_addr),
    .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
    .bus_err(bus_err), .bus_rdata(bus_rdata), .mem_pc(mem_pc),
    .mem_en(mem_en), .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_),
    .mem_exp_code(mem_exp_code), .mem_out(mem_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic we_);
    ex_en          = 1'b1;
    ex_mem_op      = op;
    ex_out         = addr;
    ex_mem_wr_data = wd;
    ex_gpr_we_     = we_;
    ex_pc          = 32'h2000 | addr;
    ex_dst_addr    = 5'd7;
    ex_exp_code    = 3'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; ex_en = 1'b0; ex_mem_op = 4'd0;
    ex_pc = '0; ex_mem_wr_data = '0; ex_dst_addr = '0; ex_gpr_we_ = 1'b1;
    ex_exp_code = '0; ex_out = '0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    tick(); tick();
    check("rst_req", bus_req, 0);
    check("rst_busy", busy, 0);
    check("rst_en", mem_en, 0);
    check("rst_we_", mem_gpr_we_, 1);
    check("rst_out", mem_out, 0);
    reset = 1'b0;
    tick();

    // LW, zero wait
    set_op(4'd1, 32'h104, 32'h0, 1'b0); bus_rdata = 32'hDEADBEEF; bus_ack = 1'b1; #1;
    check("lw_req", bus_req, 1);
    check("lw_busy", busy, 0);
    check("lw_addr", bus_addr, 32'h104);
    check("lw_fwd", fwd_data, 32'hDEADBEEF);
    tick();
    check("lw_out", mem_out, 32'hDEADBEEF);
    check("lw_we_", mem_gpr_we_, 0);
    check("lw_en", mem_en, 1);
    check("lw_pc", mem_pc, 32'h2104);
    check("lw_dst", mem_dst_addr, 7);

    // LB, ack after three cycles
    set_op(4'd4, 32'h103, 32'h0, 1'b0); bus_rdata = 32'h80FF1234; nb = 0;
    for (int i = 0; i < 4; i++) begin
      bus_ack = (i == 3); #1;
      if (busy) nb++;
      if (i == 1) check("lb_wait_req", bus_req, 1);
      if (i == 2) check("lb_hold", mem_out, 32'hDEADBEEF);
      tick();
    end
    check("lb_busy_cycles", nb, 3);
    check("lb_out", mem_out, 32'hFFFFFF80);

    // LBU, one wait cycle; ex_out moves while waiting, bus must not
    set_op(4'd5, 32'h103, 32'h0, 1'b0); bus_ack = 1'b0; #1;
    tick();
    ex_out = 32'h200; #1;
    check("lbu_held_addr", bus_addr, 32'h100);
    bus_ack = 1'b1; #1;
    check("lbu_fwd", fwd_data, 32'h80);
    tick();
    check("lbu_out", mem_out, 32'h80);

    // LW with flush in 2nd WAIT cycle, ack in 4th
    set_op(4'd1, 32'h108, 32'h0, 1'b0); bus_rdata = 32'h11223344;
    for (int i = 0; i < 5; i++) begin
      flush = (i == 2); bus_ack = (i == 4); #1;
      if (i == 3) begin
        check("fl_req", bus_req, 1);
        check("fl_hold_en", mem_en, 1);
      end
      tick();
    end
    flush = 1'b0; bus_ack = 1'b0; ex_en = 1'b0;
    check("fl_en", mem_en, 0);
    check("fl_we_", mem_gpr_we_, 1);
    check("fl_out", mem_out, 0);

    // SH and SB lane replication
    set_op(4'd7, 32'h102, 32'h0000ABCD, 1'b1); bus_ack = 1'b1; #1;
    check("sh_we", bus_we, 1);
    check("sh_be", bus_be, 4'b1100);
    check("sh_wdata", bus_wdata, 32'hABCDABCD);
    check("sh_addr", bus_addr, 32'h100);
    tick();
    check("sh_out", mem_out, 32'h102);
    check("sh_we_", mem_gpr_we_, 1);
    check("sh_exp", mem_exp_code, 0);
    set_op(4'd8, 32'h101, 32'h0000005A, 1'b1); #1;
    check("sb_be", bus_be, 4'b0010);
    check("sb_wdata", bus_wdata, 32'h5A5A5A5A);
    tick();

    // LH / LHU upper half
    set_op(4'd2, 32'h102, 32'h0, 1'b0); bus_rdata = 32'h80FF1234; #1;
    check("lh_be", bus_be, 4'b1100);
    tick();
    check("lh_out", mem_out, 32'hFFFF80FF);
    set_op(4'd3, 32'h102, 32'h0, 1'b0); tick();
    check("lhu_out", mem_out, 32'h000080FF);

    // misaligned LW
    set_op(4'd1, 32'h106, 32'h0, 1'b0); bus_ack = 1'b0; #1;
    check("mis_req", bus_req, 0);
    check("mis_busy", busy, 0);
    tick();
    check("mis_exp", mem_exp_code, 3);
    check("mis_we_", mem_gpr_we_, 1);
    check("mis_en", mem_en, 1);

    // bus error with ack
    set_op(4'd1, 32'h100, 32'h0, 1'b0); bus_ack = 1'b1; bus_err = 1'b1; tick();
    check("berr_exp", mem_exp_code, 4);
    check("berr_we_", mem_gpr_we_, 1);
    bus_err = 1'b0;

    // non-memory ops, including an undefined op code
    set_op(4'd0, 32'h12345678, 32'h0, 1'b0); #1;
    check("nop_req", bus_req, 0);
    tick();
    check("nop_out", mem_out, 32'h12345678);
    check("nop_we_", mem_gpr_we_, 0);
    set_op(4'd12, 32'h0BADF00D, 32'h0, 1'b0); #1;
    check("op12_req", bus_req, 0);
    tick();
    check("op12_out", mem_out, 32'h0BADF00D);

    // stall holds the register
    set_op(4'd1, 32'h104, 32'h0, 1'b0); bus_rdata = 32'hCAFEF00D; stall = 1'b1; tick();
    check("stall_hold", mem_out, 32'h0BADF00D);
    stall = 1'b0; tick();
    check("stall_release", mem_out, 32'hCAFEF00D);

    // reset mid-transfer, then a late ack
    set_op(4'd1, 32'h10C, 32'h0, 1'b0); bus_ack = 1'b0; #1;
    tick();
    reset = 1'b1; #1;
    check("rw_req_in_reset", bus_req, 0);
    tick();
    reset = 1'b0; ex_en = 1'b0; #1;
    check("rw_req", bus_req, 0);
    check("rw_busy", busy, 0);
    check("rw_en", mem_en, 0);
    check("rw_we_", mem_gpr_we_, 1);
    bus_ack = 1'b1; bus_rdata = 32'h55; tick();
    check("late_out", mem_out, 0);
    check("late_en", mem_en, 0);
    set_op(4'd1, 32'h110, 32'h0, 1'b0); bus_rdata = 32'h77; #1;
    check("post_busy", busy, 0);
    tick();
    check("post_out", mem_out, 32'h77);

`ifdef MEM_TIMEOUT_EN
    set_op(4'd1, 32'h114, 32'h0, 1'b0); bus_ack = 1'b0; nb = 0;
    for (int i = 0; i < 30; i++) begin
      logic b;
      #1;
      b = busy;
      if (b) nb++;
      tick();
      if (!b) break;
    end
    ex_en = 1'b0;
    check("to_busy_cycles", nb, 16);
    check("to_exp", mem_exp_code, 4);
    check("to_we_", mem_gpr_we_, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_mc.md
Name: mem_stage_mc

Overview:
- Parametrised, multi-cycle successor of the pipeline MEM stage.
- Sits between the EX/MEM and MEM/WB boundaries; drives a req/ack data-memory bus with variable latency.
- Supports byte, half and word loads (signed/unsigned) and stores, with byte enables.
- Detects misalignment and bus errors, raises busy while a transfer is outstanding, and registers results into the MEM pipeline register.

Parameters:
- DATA_W, 32, data/word width in bits; power of 2, >=32.
- ADDR_W, 32, byte address width.
- REG_ADDR_W, 5, GPR index width.
- EXP_W, 3, exception-code width.
- TIMEOUT, 15, max ack wait cycles before a bus error (used only with MEM_TIMEOUT_EN).

Ports:
- clk in 1 clock.
- reset in 1 synchronous, active-high reset.
- stall in 1 hold MEM register.
- flush in 1 squash current op.
- busy out 1 transfer outstanding; combine into global stall.
- fwd_data out DATA_W bypass value (combinational out).
- ex_pc in ADDR_W.
- ex_en in 1.
- ex_mem_op in 4 memory op code.
- ex_mem_wr_data in DATA_W store data.
- ex_dst_addr in REG_ADDR_W.
- ex_gpr_we_ in 1 active-low write enable.
- ex_exp_code in EXP_W.
- ex_out in DATA_W ALU result / effective address.
- bus_req out 1.
- bus_we out 1.
- bus_addr out ADDR_W word-aligned.
- bus_wdata out DATA_W lane-replicated.
- bus_be out DATA_W/8.
- bus_ack in 1.
- bus_err in 1.
- bus_rdata in DATA_W.
- mem_pc out ADDR_W.
- mem_en out 1.
- mem_dst_addr out REG_ADDR_W.
- mem_gpr_we_ out 1.
- mem_exp_code out EXP_W.
- mem_out out DATA_W.

Behaviour:
- Op codes: NOP=0, LW=1, LH=2, LHU=3, LB=4, LBU=5, SW=6, SH=7, SB=8; 9-15 are treated as NOP.
- Exception codes: NONE=0, MISS_ALIGN=3, BUS_ERR=4.
- Access condition: access = ex_en & op in 1..8 & aligned & ex_exp_code==NONE & !flush.
- Alignment rule: word requires addr[1:0]==0 (generally addr[log2(DATA_W/8)-1:0]==0); half requires addr[0]==0; byte is always aligned.
- Misaligned op: no bus_req; captured exp_code=MISS_ALIGN; mem_gpr_we_=1.
- FSM states: IDLE, WAIT.
- IDLE: bus_req=access, combinational from ex_*.
  - If bus_ack in the same cycle, the transfer completes with zero wait and busy=0.
  - If no bus_ack, busy=1 and the FSM goes to WAIT.
- WAIT: bus_req=1; bus_addr/we/be/wdata held from registered copies; busy=!bus_ack.
  - On bus_ack, the FSM goes to IDLE and the result is captured.
- bus_err with bus_ack: exp_code=BUS_ERR, gpr_we_=1, load data discarded.
- bus_err without bus_ack is ignored.
- Load data: select the lane by low address bits; LB/LH sign-extend, LBU/LHU zero-extend to DATA_W.
- Store data: byte/half replicated across all lanes; bus_be one-hot per byte/half lane, all ones for word.
- Non-memory op: out=ex_out.
- Loads: out=extended rdata, valid only in the ack cycle.
- MEM register update: on clock edge when !stall & !busy.
  - If flush, or !ex_en: en=0, gpr_we_=1, exp_code=0, out=0, pc and dst=0.
  - Otherwise capture ex_* with the computed out and exp_code.
- Flush while in WAIT: set drop flag; stay in WAIT until ack (the bus is not aborted); then write a bubble; clear the flag.
- Reset (any state, including mid-transfer):
  - state=IDLE, drop=0, bus_req=0.
  - All MEM outputs 0 except mem_gpr_we_=1.
  - A late ack after reset is ignored.
- stall=1 with busy=0 holds the register; a zero-wait transfer may still occur, so upstream must hold ex_* stable.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- When defined, a counter of width clog2(TIMEOUT+1) increments in WAIT. When it reaches TIMEOUT without ack, the FSM forces IDLE, bus_req deasserts, and the op is captured with exp_code=BUS_ERR and gpr_we_=1. The counter clears on entry to WAIT.
- When undefined, no counter exists and WAIT lasts indefinitely until ack.

Decomposition:
- Shared package/header mem_defs holds:
  - op-code constants;
  - exception codes;
  - RESET_ENABLE/ENABLE/DISABLE constants;
  - the width macro for the op bus.
- One natural sub-module, mem_align (combinational). It computes aligned, be, replicated wdata, and load extension from op, addr low bits, wr_data and rdata.

Test Plan:
- LW addr 0x104, ack same cycle, rdata 0xDEADBEEF -> busy never 1; next edge mem_out=0xDEADBEEF, mem_gpr_we_=0.
- LB addr 0x103, rdata 0x80FF1234, ack after 3 cycles -> busy=1 for 3 cycles; mem_out=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x102, wr_data 0x0000ABCD -> bus_we=1, bus_be=4'b1100, bus_wdata=0xABCDABCD, bus_addr=0x100.
- LW addr 0x106 -> no bus_req; mem_exp_code=3, mem_gpr_we_=1.
- LW with flush asserted in the 2nd WAIT cycle, ack in the 4th -> bubble written (mem_en=0). Reset asserted in WAIT -> bus_req=0 the next cycle; a later ack has no effect.
- With MEM_TIMEOUT_EN and TIMEOUT=15: no ack -> busy high exactly 16 cycles (issue + 15 WAIT); mem_exp_code=4.
